// File: rtl/rq_encode_loader_pkg.sv
// Shared definitions for the Rq/Rounded encode loader: parameter sets, the
// divide-by-3 reciprocal, loader FSM encoding and the RAM port widths.

`ifndef RP_DEPTH
`define RP_DEPTH 10
`endif
`ifndef RP_D_SIZE
`define RP_D_SIZE 16
`endif

package rq_encode_loader_pkg;

  // sntrup761 is the default parameter set; sntrup653 kept for reuse.
  localparam int P_761 = 761;
  localparam int Q_4591 = 4591;
  localparam int P_653 = 653;
  localparam int Q_4621 = 4621;

  // floor(x / 3) == (x * 10923) >> 15 for every x below 2^14.
  localparam int DIV3_MUL = 10923;
  localparam int DIV3_SHIFT = 15;

  localparam int COEF_W = 14;
  localparam int SUM_W = 15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FIRE  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

  function automatic int q12_of(input int q);
    return (q - 1) / 2;
  endfunction

endpackage

// File: rtl/rq_round_unit.sv
// Two-stage coefficient pipeline: stage 1 offsets by Q12 and clamps to
// [0, Q-1] with a range flag, stage 2 selects Rq value or floor(/3).

module rq_round_unit
  import rq_encode_loader_pkg::*;
#(
  parameter int Q  = Q_4591,
  parameter int AW = `RP_DEPTH,
  parameter int DW = `RP_D_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic                in_valid,
  input  logic [COEF_W-1:0]   in_coef,
  input  logic [AW-1:0]       in_idx,
  output logic                range_err,
  output logic                valid,
  output logic [AW-1:0]       idx,
  output logic [DW-1:0]       r
);

  localparam int Q12 = q12_of(Q);
  localparam logic signed [SUM_W-1:0] Q12_S = SUM_W'(Q12);
  localparam logic signed [SUM_W-1:0] QM1_S = SUM_W'(Q - 1);

  logic signed [SUM_W-1:0] coef_ext;
  logic signed [SUM_W-1:0] sum;
  logic [COEF_W-1:0]       sum_clamped;
  logic                    oor;

  logic                    s1_valid;
  logic [COEF_W-1:0]       s1_sum;
  logic                    s1_oor;
  logic [AW-1:0]           s1_idx;

  logic [27:0]             prod;
  logic [27:0]             quo;
  logic [COEF_W-1:0]       r_nxt;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    coef_ext    = {in_coef[COEF_W-1], in_coef};
    sum         = coef_ext + Q12_S;
    oor         = 1'b0;
    sum_clamped = sum[COEF_W-1:0];
    if (sum[SUM_W-1]) begin
      oor         = 1'b1;
      sum_clamped = '0;
    end else if (sum > QM1_S) begin
      oor         = 1'b1;
      sum_clamped = QM1_S[COEF_W-1:0];
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_oor   <= 1'b0;
      s1_idx   <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sum <= sum_clamped;
        s1_oor <= oor;
        s1_idx <= in_idx;
      end
    end
  end

  always_comb begin
    prod  = 28'(s1_sum) * 28'(DIV3_MUL);
    quo   = prod >> DIV3_SHIFT;
    r_nxt = mode ? s1_sum : quo[COEF_W-1:0];
  end

  // Data registers are reset too: the RAM port must read all-zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      idx   <= '0;
      r     <= '0;
    end else begin
      valid <= s1_valid;
      if (s1_valid) begin
        idx <= s1_idx;
        r   <= DW'(r_nxt);
      end
    end
  end

  assign range_err = s1_valid && s1_oor;

endmodule

// File: rtl/rq_encode_loader.sv
// Streams P signed coefficients through the round unit into the encoder
// input RAM, then starts the encoder and reports completion.

module rq_encode_loader
  import rq_encode_loader_pkg::*;
#(
  parameter int P = P_761,
  parameter int Q = Q_4591
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [COEF_W-1:0]     in_coef,
  output logic                  rp_we,
  output logic [`RP_DEPTH-1:0]  rp_aw,
  output logic [`RP_D_SIZE-1:0] rp_dw,
  output logic                  enc_start,
  input  logic                  enc_done,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int AW = `RP_DEPTH;
  localparam int DW = `RP_D_SIZE;
  localparam int CW = $clog2(P + 1);

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic            mode_q;
  logic            xfer;
  logic            last_xfer;
  logic            last_write;
  logic            ru_err;

  assign xfer       = in_valid && in_ready;
  assign last_xfer  = xfer && (cnt == CW'(P - 1));
  assign last_write = rp_we && (rp_aw == AW'(P - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (xfer) state_nxt = last_xfer ? ST_DRAIN : ST_LOAD;
      ST_LOAD:  if (last_xfer) state_nxt = ST_DRAIN;
      ST_DRAIN: if (last_write) state_nxt = ST_FIRE;
      ST_FIRE:  state_nxt = ST_WAIT;
      ST_WAIT:  if (enc_done) state_nxt = ST_FIN;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // in_ready is gated by rst so the producer sees it low throughout reset.
  always_comb begin
    in_ready  = ((state == ST_IDLE) || (state == ST_LOAD)) && (cnt < CW'(P)) && !rst;
    enc_start = (state == ST_FIRE);
    done      = (state == ST_FIN);
    busy      = (state != ST_IDLE);
  end

  // Mode and err belong to the run: both are set up by its first transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      mode_q <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (state == ST_FIN) begin
        cnt <= '0;
      end else if (xfer) begin
        cnt <= cnt + 1'b1;
      end
      if (xfer && (state == ST_IDLE)) begin
        mode_q <= mode;
        err    <= 1'b0;
      end else if (ru_err) begin
        err <= 1'b1;
      end
    end
  end

  rq_round_unit #(
    .Q  (Q),
    .AW (AW),
    .DW (DW)
  ) u_round (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode_q),
    .in_valid  (xfer),
    .in_coef   (in_coef),
    .in_idx    (AW'(cnt)),
    .range_err (ru_err),
    .valid     (rp_we),
    .idx       (rp_aw),
    .r         (rp_dw)
  );

endmodule

// File: tb/tb_rq_encode_loader.sv
// Directed bench for rq_encode_loader: table of hand-computed coefficient
// results per run, a write monitor with latency/address checks, and
// hand-written sequences for reset, gaps and encoder handshake.

module tb_rq_encode_loader;
  import rq_encode_loader_pkg::*;

  localparam int P  = 761;
  localparam int AW = `RP_DEPTH;
  localparam int DW = `RP_D_SIZE;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                mode = 1'b0;
  logic                in_valid = 1'b0;
  logic [13:0]         in_coef = '0;
  logic                enc_done = 1'b0;
  logic                in_ready;
  logic                rp_we;
  logic [AW-1:0]       rp_aw;
  logic [DW-1:0]       rp_dw;
  logic                enc_start;
  logic                busy;
  logic                done;
  logic                err;

  rq_encode_loader #(.P(P), .Q(4591)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_coef   (in_coef),
    .rp_we     (rp_we),
    .rp_aw     (rp_aw),
    .rp_dw     (rp_dw),
    .enc_start (enc_start),
    .enc_done  (enc_done),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  typedef struct {
    logic mode;
    int   coef;
    int   exp_r;
    logic exp_err;
  } vec_t;

  typedef struct {
    int addr;
    int r;
    int cyc;
  } exp_t;

  vec_t tbl[19];
  exp_t exp_q[$];
  int   n_writes;
  int   n_starts;
  int   n_done;
  logic prev_err;

  task automatic set_vec(input int i, input logic m, input int c, input int r, input logic e);
    tbl[i].mode    = m;
    tbl[i].coef    = c;
    tbl[i].exp_r   = r;
    tbl[i].exp_err = e;
  endtask

  // Independent reference: clamp then plain integer division.
  function automatic int model_r(input logic m, input int f);
    int s;
    s = f + 2295;
    if (s < 0) s = 0;
    if (s > 4590) s = 4590;
    return m ? s : s / 3;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (rp_we) begin
        if (exp_q.size() == 0) begin
          check("spurious_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rp_aw", 32'(rp_aw), e.addr);
          check("rp_dw", 32'(rp_dw), e.r);
          check("write_latency", cyc - e.cyc, 2);
        end
        n_writes++;
      end
      if (enc_start) begin
        n_starts++;
        check("writes_before_start", n_writes, P);
      end
      if (done) n_done++;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 0);
    check({tag, "_rp_we"}, 32'(rp_we), 0);
    check({tag, "_rp_aw"}, 32'(rp_aw), 0);
    check({tag, "_rp_dw"}, 32'(rp_dw), 0);
    check({tag, "_enc_start"}, 32'(enc_start), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_err"}, 32'(err), 0);
  endtask

  task automatic send(input logic [13:0] f, input int exp_r, input int addr);
    int t;
    t        = 0;
    in_valid = 1'b1;
    in_coef  = f;
    @(negedge clk);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back('{addr, exp_r, cyc});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic abort_run();
    int t;
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(posedge clk);
    exp_q.delete();
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready_after_release", 32'(in_ready), 1);
    for (t = 0; t < 20; t++) @(negedge clk);
    check("abort_no_enc_start", n_starts, 0);
    check("abort_busy_idle", 32'(busy), 0);
    prev_err = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One polynomial: table entries lo..lo+n-1 at the first addresses, model
  // values after that; optional stray enc_done and optional reset abort.
  task automatic run_poly(input int lo, input int n, input int gap, input int done_at, input int abort_at);
    logic m;
    logic any_err;
    int   f;
    int   r;
    int   t;
    m       = tbl[lo].mode;
    any_err = 1'b0;
    for (int k = 0; k < n; k++) any_err = any_err | tbl[lo + k].exp_err;
    n_writes = 0;
    n_starts = 0;
    n_done   = 0;
    mode     = m;
    check("err_before_run", 32'(err), 32'(prev_err));
    for (int i = 0; i < P; i++) begin
      if (i == abort_at) begin
        abort_run();
        return;
      end
      if (i < n) begin
        f = tbl[lo + i].coef;
        r = tbl[lo + i].exp_r;
      end else begin
        f = ((i * 37) % 4591) - 2295;
        r = model_r(m, f);
      end
      if (i == done_at) enc_done = 1'b1;
      send(14'(f), r, i);
      enc_done = 1'b0;
      if (i == 0) begin
        check("err_cleared_first_accept", 32'(err), 0);
        check("busy_after_accept", 32'(busy), 1);
      end
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    check("in_ready_low_after_last", 32'(in_ready), 0);
    t = 0;
    while (n_starts == 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("enc_start_seen", n_starts, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("write_count", n_writes, P);
    check("pending_writes", exp_q.size(), 0);
    check("wait_busy", 32'(busy), 1);
    check("wait_no_done", n_done, 0);
    enc_done = 1'b1;
    @(posedge clk);
    #1;
    enc_done = 1'b0;
    check("done_pulse", 32'(done), 1);
    check("busy_during_fin", 32'(busy), 1);
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(done), 0);
    check("busy_after_fin", 32'(busy), 0);
    check("in_ready_idle", 32'(in_ready), 1);
    check("single_enc_start", n_starts, 1);
    check("done_count", n_done, 1);
    check("err_end_of_run", 32'(err), 32'(any_err));
    prev_err = any_err;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Run 1: Rq encode, in-range.
    set_vec(0,  1'b1, -2295, 0,    1'b0);
    set_vec(1,  1'b1, 0,     2295, 1'b0);
    set_vec(2,  1'b1, 2295,  4590, 1'b0);
    set_vec(3,  1'b1, 1000,  3295, 1'b0);
    set_vec(4,  1'b1, -1,    2294, 1'b0);
    // Run 2: Rounded encode, floor((F+2295)/3).
    set_vec(5,  1'b0, -2295, 0,    1'b0);
    set_vec(6,  1'b0, 0,     765,  1'b0);
    set_vec(7,  1'b0, 2295,  1530, 1'b0);
    set_vec(8,  1'b0, 2,     765,  1'b0);
    set_vec(9,  1'b0, 3,     766,  1'b0);
    set_vec(10, 1'b0, 1,     765,  1'b0);
    // Run 3: Rq encode, out-of-range clamps.
    set_vec(11, 1'b1, 2296,  4590, 1'b1);
    set_vec(12, 1'b1, -2296, 0,    1'b1);
    set_vec(13, 1'b1, 8191,  4590, 1'b1);
    set_vec(14, 1'b1, -8192, 0,    1'b1);
    // Run 4: Rounded, aborted by reset at index 300.
    set_vec(15, 1'b0, 100,   798,  1'b0);
    set_vec(16, 1'b0, -100,  731,  1'b0);
    // Run 5: Rounded, out-of-range after abort.
    set_vec(17, 1'b0, 8191,  1530, 1'b1);
    set_vec(18, 1'b0, -3000, 0,    1'b1);

    prev_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", 32'(in_ready), 1);
    @(posedge clk);
    #1;

    run_poly(0,  5, 0, 100, -1);
    run_poly(5,  6, 1, -1,  -1);
    run_poly(11, 4, 0, -1,  -1);
    run_poly(15, 2, 0, -1,  300);
    run_poly(17, 2, 0, -1,  -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
